// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - multi-cycle instruction fetch unit feeding the decode stage
//
// Purpose:
//   Fetches one instruction word at a time from instruction memory.
//   The returned word and its PC are held for the decoder until it accepts them.
//   The unit then waits for the commit-time next PC (dnpc) before it fetches again.
//   Misaligned targets and response timeouts are reported through fetch_err with inst forced to 0.
//   An ebreak retirement (halt on commit) parks the unit until reset.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   imem_req_valid/ready   fetch request handshake
//   imem_req_addr          fetch address (always pc_q)
//   imem_rsp_valid/data    single-cycle response pulse and instruction word
//   imem_rsp_err           access fault, qualified by imem_rsp_valid
//   inst_valid/ready       instruction handshake toward decode
//   inst, inst_pc          held instruction word and its PC
//   fetch_err              held instruction is an error marker (inst == 0)
//   commit_valid, dnpc     retirement of the held instruction and the next PC
//   halt                   with commit_valid: stop fetching
//   fetch_cnt              number of instructions accepted by decode (wraps)

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err,
  input  logic        commit_valid,
  input  logic [31:0] dnpc,
  input  logic        halt,
  output logic [31:0] fetch_cnt
);

  // The timeout counter is 8 bits wide, so the limit is taken modulo 256.
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT_RSP,
    HOLD,
    WAIT_COMMIT,
    HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [7:0]  tmo_cnt_q;

  // Datapath update strobes produced by the FSM.
  logic        ld_rsp;    // capture a memory response
  logic        ld_tmo;    // capture a timeout error marker
  logic        ld_mis;    // capture a misaligned-target error marker
  logic        ld_pc;     // take dnpc as the new fetch PC
  logic        cnt_inc;   // decoder accepted the held instruction
  logic        tmo_clr;
  logic        tmo_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    ld_rsp         = 1'b0;
    ld_tmo         = 1'b0;
    ld_mis         = 1'b0;
    ld_pc          = 1'b0;
    cnt_inc        = 1'b0;
    tmo_clr        = 1'b0;
    tmo_inc        = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = REQ;
      end

      REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          tmo_clr = 1'b1;
          state_d = WAIT_RSP;
        end
      end

      // A response arriving in the same cycle as the timeout takes priority.
      WAIT_RSP: begin
        if (imem_rsp_valid) begin
          ld_rsp  = 1'b1;
          state_d = HOLD;
        end else if (tmo_cnt_q == TMO_LIMIT) begin
          ld_tmo  = 1'b1;
          state_d = HOLD;
        end else begin
          tmo_inc = 1'b1;
        end
      end

      HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          cnt_inc = 1'b1;
          state_d = WAIT_COMMIT;
        end
      end

      // Halt wins over dnpc; a misaligned dnpc skips memory entirely.
      WAIT_COMMIT: begin
        if (commit_valid) begin
          if (halt) begin
            state_d = HALTED;
          end else begin
            ld_pc = 1'b1;
            if (dnpc[1:0] == 2'b00) begin
              state_d = REQ;
            end else begin
              ld_mis  = 1'b1;
              state_d = HOLD;
            end
          end
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      inst      <= 32'd0;
      inst_pc   <= RESET_PC;
      fetch_err <= 1'b0;
      fetch_cnt <= 32'd0;
      tmo_cnt_q <= 8'd0;
    end else begin
      if (ld_pc) begin
        pc_q <= dnpc;
      end

      if (ld_rsp) begin
        inst      <= imem_rsp_err ? 32'd0 : imem_rsp_data;
        inst_pc   <= pc_q;
        fetch_err <= imem_rsp_err;
      end else if (ld_tmo) begin
        inst      <= 32'd0;
        inst_pc   <= pc_q;
        fetch_err <= 1'b1;
      end else if (ld_mis) begin
        inst      <= 32'd0;
        inst_pc   <= dnpc;
        fetch_err <= 1'b1;
      end

      if (cnt_inc) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end

      if (tmo_clr) begin
        tmo_cnt_q <= 8'd0;
      end else if (tmo_inc) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
    end
  end

  assign imem_req_addr = pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int unsigned TIMEOUT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;
  logic        commit_valid = 1'b0;
  logic [31:0] dnpc = 32'd0;
  logic        halt = 1'b0;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: where the next fetch must go and how many
  // instructions the decoder should have accepted so far.
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  logic [31:0] r, d, tgt;
  logic        e;
  int          n;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_err      (fetch_err),
    .commit_valid   (commit_valid),
    .dnpc           (dnpc),
    .halt           (halt),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed still running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_values();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, RESET_PC);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_addr", imem_req_addr, RESET_PC);
  endtask

  // Release reset; the unit spends one cycle in BOOT without requesting.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("boot_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_pc  = RESET_PC;
    exp_cnt = 32'd0;
    chk_reset_values();
  endtask

  // Request phase: stall the memory for `stall` cycles, then handshake.
  task automatic req_phase(input int stall);
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 1'b0;
      chk("req_valid_stall", {31'd0, imem_req_valid}, 32'd1);
      chk("req_addr_stall", imem_req_addr, exp_pc);
      step();
    end
    imem_req_ready = 1'b1;
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_req_addr, exp_pc);
    step();
    imem_req_ready = 1'b0;
    chk("req_drop_after_hs", {31'd0, imem_req_valid}, 32'd0);
  endtask

  // Response phase: pulse a response `lat` cycles after the handshake.
  task automatic rsp_phase(input int lat, input logic [31:0] data, input logic err);
    for (int i = 1; i < lat; i++) begin
      chk("wait_no_inst", {31'd0, inst_valid}, 32'd0);
      chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
      step();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    chk("hold_valid", {31'd0, inst_valid}, 32'd1);
    chk("hold_inst", inst, err ? 32'd0 : data);
    chk("hold_pc", inst_pc, exp_pc);
    chk("hold_err", {31'd0, fetch_err}, {31'd0, err});
  endtask

  // Decoder phase: stall `stall` cycles (with stray commits that must be
  // ignored), then accept once.
  task automatic deliver(input int stall, input logic [31:0] x_inst,
                         input logic [31:0] x_pc, input logic x_err);
    for (int i = 0; i < stall; i++) begin
      inst_ready   = 1'b0;
      commit_valid = (i == 0);
      dnpc         = 32'h1234_5678;
      step();
      commit_valid = 1'b0;
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, x_inst);
      chk("stall_pc", inst_pc, x_pc);
      chk("stall_err", {31'd0, fetch_err}, {31'd0, x_err});
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("fetch_cnt", fetch_cnt, exp_cnt);
    chk("post_accept_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  task automatic commit(input int delay, input logic [31:0] npc, input logic h);
    for (int i = 0; i < delay; i++) begin
      chk("wc_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("wc_no_inst", {31'd0, inst_valid}, 32'd0);
      step();
    end
    commit_valid = 1'b1;
    dnpc         = npc;
    halt         = h;
    step();
    commit_valid = 1'b0;
    halt         = 1'b0;
    if (!h) exp_pc = npc;
  endtask

  // Full normal fetch-and-deliver of one instruction at exp_pc.
  task automatic fetch(input int rstall, input int lat, input logic [31:0] data,
                       input logic err, input int dstall);
    req_phase(rstall);
    rsp_phase(lat, data, err);
    deliver(dstall, err ? 32'd0 : data, exp_pc, err);
  endtask

  // Misaligned redirect: goes straight to HOLD with an error marker.
  task automatic misaligned(input int dstall);
    chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("mis_valid", {31'd0, inst_valid}, 32'd1);
    chk("mis_inst", inst, 32'd0);
    chk("mis_pc", inst_pc, exp_pc);
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    deliver(dstall, 32'd0, exp_pc, 1'b1);
  endtask

  initial begin
    exp_pc  = RESET_PC;
    exp_cnt = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_values();
    release_reset();

    // Boot fetch, response two cycles after the handshake.
    fetch(0, 2, 32'h0000_0413, 1'b0, 0);

    // Backpressure on both sides.
    commit(1, 32'h8000_0004, 1'b0);
    fetch(3, 1, 32'h0011_0093, 1'b0, 4);

    // Redirect.
    commit(0, 32'h8000_0010, 1'b0);
    fetch(0, 1, 32'h00A0_0513, 1'b0, 0);

    // Misaligned target.
    commit(2, 32'h8000_0006, 1'b0);
    misaligned(1);

    // Timeout with no response, then a late response that must be ignored.
    commit(0, 32'h8000_0020, 1'b0);
    req_phase(0);
    n = 0;
    while (!inst_valid && n < int'(TIMEOUT) + 3) begin
      chk("tmo_no_req", {31'd0, imem_req_valid}, 32'd0);
      step();
      n++;
    end
    chk("tmo_window", {31'd0, (n >= int'(TIMEOUT) && n <= int'(TIMEOUT) + 2)}, 32'd1);
    chk("tmo_inst", inst, 32'd0);
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_pc", inst_pc, exp_pc);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0073;
    step();
    imem_rsp_valid = 1'b0;
    chk("late_rsp_inst", inst, 32'd0);
    chk("late_rsp_err", {31'd0, fetch_err}, 32'd1);
    deliver(0, 32'd0, exp_pc, 1'b1);

    // Memory fault, then a normal fetch.
    commit(0, 32'h8000_0024, 1'b0);
    fetch(1, 2, 32'hFFFF_FFFF, 1'b1, 0);
    commit(0, 32'h8000_0028, 1'b0);
    fetch(0, 1, 32'h0020_8133, 1'b0, 1);

    // Randomized traffic.
    for (int k = 0; k < 30; k++) begin
      r = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        tgt = {r[31:2], 2'(($urandom_range(1, 3)))};
        commit($urandom_range(0, 2), tgt, 1'b0);
        misaligned($urandom_range(0, 3));
      end else begin
        tgt = {r[31:2], 2'b00};
        commit($urandom_range(0, 2), tgt, 1'b0);
        d = $urandom;
        e = ($urandom_range(0, 7) == 0);
        fetch($urandom_range(0, 3), $urandom_range(1, 3), d, e, $urandom_range(0, 3));
      end
    end

    // Halt: no further activity.
    commit(1, 32'h8000_0100, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("halt_no_inst", {31'd0, inst_valid}, 32'd0);
      commit_valid = (i == 3);
      dnpc         = 32'h8000_0200;
      step();
    end
    commit_valid = 1'b0;
    chk("halt_cnt", fetch_cnt, exp_cnt);

    // Reset out of HALTED, start a fetch, then reset during WAIT_RSP.
    apply_reset();
    release_reset();
    req_phase(0);
    apply_reset();
    release_reset();
    // Late response from the aborted request arrives while in REQ.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD_0BAD;
    imem_rsp_err   = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk("late_ignored_valid", {31'd0, inst_valid}, 32'd0);
    chk("late_ignored_inst", inst, 32'd0);
    d = $urandom;
    fetch(0, 2, d, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
